// File: rtl/gate_alu.sv
// gate_alu: bitwise logic unit with a 2-entry output FIFO and valid/ready
// handshakes on both sides. Each accepted operation produces one result,
// which is visible at the buffer head on the following cycle.
// Optional feature: define GATE_ALU_CNT_EN to add the 16-bit accepted-operation
// counter on port ops. Without that macro, the port and counter are absent.
module gate_alu #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z0,
  output logic             zf,
  output logic             out_valid,
  input  logic             out_ready
`ifdef GATE_ALU_CNT_EN
  ,
  output logic [15:0]      ops
`endif
);

  // The occupancy encoding is fixed, so the constants stay plain.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // The pointer and state logic below only supports a two-entry buffer.
  generate
    if (DEPTH != 2) begin : g_bad_depth
      $error("gate_alu: DEPTH must be 2");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("gate_alu: WIDTH must be in 1..32");
    end
  endgenerate

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] mem [0:1];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             alive;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = alive & (state != ST_FULL);
  assign head      = mem[rd_ptr];
  assign z0        = out_valid ? head : '0;
  assign zf        = out_valid & ~|head;

  // Compute the bitwise result for the operands offered this cycle.
  always_comb begin
    result = x0;
    case (op)
      3'd0:    result = x0 & x1;
      3'd1:    result = x0 | x1;
      3'd2:    result = x0 ^ x1;
      3'd3:    result = ~(x0 & x1);
      3'd4:    result = ~(x0 | x1);
      3'd5:    result = ~(x0 ^ x1);
      3'd6:    result = ~x0;
      default: result = x0;
    endcase
  end

  // Determine the next occupancy from this cycle's push and pop.
  always_comb begin
    next_state = state;
    case (state)
      ST_EMPTY: if (push) next_state = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      next_state = ST_FULL;
        else if (pop && !push) next_state = ST_EMPTY;
      end
      ST_FULL:  if (pop) next_state = ST_ONE;
      default:  next_state = ST_EMPTY;
    endcase
  end

  // Hold in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // Advance occupancy and the read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Store each accepted result at the write pointer. Reset clears both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= result;
    end
  end

`ifdef GATE_ALU_CNT_EN
  // Count accepted operations. The counter wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ops <= 16'h0000;
    else if (push) ops <= ops + 16'h0001;
  end
`endif

endmodule
